// File: rtl/aes_pkg.sv
// Shared AES constants, Rcon table and key-expander FSM state type.
// Used by key_expander (optional round-key stream: KEY_EXPANDER_RK_STREAM_EN) and aes_sbox.
package aes_pkg;

  localparam int unsigned AES_NR        = 10;
  localparam int unsigned AES_KEY_W     = 128;
  localparam int unsigned AES_EXP_KEY_W = 1408;
  localparam int unsigned AES_RND_W     = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    DONE   = 2'd2
  } aes_state_e;

  // Round constant for rounds 1..10; zero elsewhere.
  function automatic logic [7:0] aes_rcon(input logic [AES_RND_W-1:0] rnd);
    logic [7:0] rc;
    case (rnd)
      4'd1:    rc = 8'h01;
      4'd2:    rc = 8'h02;
      4'd3:    rc = 8'h04;
      4'd4:    rc = 8'h08;
      4'd5:    rc = 8'h10;
      4'd6:    rc = 8'h20;
      4'd7:    rc = 8'h40;
      4'd8:    rc = 8'h80;
      4'd9:    rc = 8'h1b;
      4'd10:   rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return rc;
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// 8-bit combinational AES forward S-box; shared by key expansion and SubBytes.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] i_byte,
  output logic [7:0] o_byte_c
);

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  always_comb begin
    o_byte_c = SBOX[i_byte];
  end

endmodule

// File: rtl/key_expander.sv
// Iterative AES-128 key expansion: one round key per clock into a packed 11-slot register.
// Optional round-key stream outputs are enabled with KEY_EXPANDER_RK_STREAM_EN.
module key_expander
  import aes_pkg::*;
#(
  parameter int unsigned NR = AES_NR  // must be 10 (AES-128)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [AES_KEY_W-1:0]     cipher_key,
  output logic                     busy,
  output logic                     key_valid,
  output logic [AES_EXP_KEY_W-1:0] expanded_key
`ifdef KEY_EXPANDER_RK_STREAM_EN
  ,
  output logic                     rk_strobe,
  output logic [AES_RND_W-1:0]     rk_index,
  output logic [AES_KEY_W-1:0]     rk_data
`endif
);

  aes_state_e               r_state, w_state_d;
  logic [AES_RND_W-1:0]     r_rnd, w_rnd_d;
  logic                     r_busy, w_busy_d;
  logic                     r_key_valid, w_key_valid_d;
  logic [AES_EXP_KEY_W-1:0] r_exp, w_exp_d;
  logic [AES_KEY_W-1:0]     r_last, w_last_d;
  logic                     w_expand_we;

  logic [31:0]          w_rot;
  logic [31:0]          w_sub;
  logic [31:0]          w_temp;
  logic [AES_KEY_W-1:0] w_next;

  // SubWord(RotWord(w3)) from the most recently written slot
  assign w_rot = {r_last[23:0], r_last[31:24]};

  for (genvar g = 0; g < 4; g++) begin : g_sbox
    aes_sbox u_sbox (
      .i_byte   (w_rot[8*g +: 8]),
      .o_byte_c (w_sub[8*g +: 8])
    );
  end

  assign w_temp = w_sub ^ {aes_rcon(r_rnd), 24'h0};

  always_comb begin
    w_next[127:96] = r_last[127:96] ^ w_temp;
    w_next[95:64]  = r_last[95:64]  ^ w_next[127:96];
    w_next[63:32]  = r_last[63:32]  ^ w_next[95:64];
    w_next[31:0]   = r_last[31:0]   ^ w_next[63:32];
  end

  always_comb begin
    w_state_d     = r_state;
    w_rnd_d       = r_rnd;
    w_busy_d      = r_busy;
    w_key_valid_d = r_key_valid;
    w_exp_d       = r_exp;
    w_last_d      = r_last;
    w_expand_we   = 1'b0;
    case (r_state)
      IDLE, DONE: begin
        if (start) begin
          w_state_d                  = EXPAND;
          w_rnd_d                    = AES_RND_W'(1);
          w_busy_d                   = 1'b1;
          w_key_valid_d              = 1'b0;
          w_exp_d                    = '0;
          w_exp_d[AES_KEY_W-1:0]     = cipher_key;
          w_last_d                   = cipher_key;
        end
      end
      EXPAND: begin
        w_expand_we = 1'b1;
        w_last_d    = w_next;
        for (int s = 1; s <= int'(NR); s++) begin
          if (r_rnd == AES_RND_W'(s)) w_exp_d[AES_KEY_W*s +: AES_KEY_W] = w_next;
        end
        if (r_rnd == AES_RND_W'(NR)) begin
          w_state_d     = DONE;
          w_busy_d      = 1'b0;
          w_key_valid_d = 1'b1;
        end else begin
          w_rnd_d = r_rnd + AES_RND_W'(1);
        end
      end
      default: w_state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_rnd       <= '0;
      r_busy      <= 1'b0;
      r_key_valid <= 1'b0;
      r_exp       <= '0;
      r_last      <= '0;
    end else begin
      r_state     <= w_state_d;
      r_rnd       <= w_rnd_d;
      r_busy      <= w_busy_d;
      r_key_valid <= w_key_valid_d;
      r_exp       <= w_exp_d;
      r_last      <= w_last_d;
    end
  end

  assign busy         = r_busy;
  assign key_valid    = r_key_valid;
  assign expanded_key = r_exp;

`ifdef KEY_EXPANDER_RK_STREAM_EN
  logic                 r_rk_strobe;
  logic [AES_RND_W-1:0] r_rk_index;
  logic [AES_KEY_W-1:0] r_rk_data;

  // Each slot is published the same edge it is written, so round 1 can start early
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rk_strobe <= 1'b0;
      r_rk_index  <= '0;
      r_rk_data   <= '0;
    end else begin
      r_rk_strobe <= w_expand_we;
      if (w_expand_we) begin
        r_rk_index <= r_rnd;
        r_rk_data  <= w_next;
      end
    end
  end

  assign rk_strobe = r_rk_strobe;
  assign rk_index  = r_rk_index;
  assign rk_data   = r_rk_data;
`endif

endmodule
